// File: rtl/ultrasonic_ranger_p.sv
// ultrasonic_ranger_p: HC-SR04 style ranger with BCD distance, timeout, overrange and continuous mode.
// Optional echo persistence filter enabled by defining US_ECHO_FILTER_EN.
module ultrasonic_ranger_p #(
  parameter int TRIG_HIGH_CYC    = 500,
  parameter int PERIOD_CYC       = 1_000_000,
  parameter int TICK_DIV         = 2941,
  parameter int BCD_DIGITS       = 4,
  parameter int RISE_TIMEOUT_CYC = 1_500_000,
  parameter int ECHO_FILT_LEN    = 4
) (
  input  logic                    CLK_50M,
  input  logic                    RST,
  input  logic                    Echo,
  input  logic                    mode,
  input  logic                    start,
  output logic                    Trig,
  output logic [4*BCD_DIGITS-1:0] data,
  output logic                    data_valid,
  output logic                    timeout,
  output logic                    overrange,
  output logic                    busy
);
  localparam int PW = $clog2(PERIOD_CYC);
  localparam int CMAX = (TRIG_HIGH_CYC > RISE_TIMEOUT_CYC) ? TRIG_HIGH_CYC : RISE_TIMEOUT_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = 4 * BCD_DIGITS;
  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_DONE} state_t;
  if (TICK_DIV < 2 || ECHO_FILT_LEN < 2 || PERIOD_CYC <= TRIG_HIGH_CYC || TRIG_HIGH_CYC < 1)
    $error("ultrasonic_ranger_p: illegal parameter set");
  state_t r_state, w_next;
  logic r_s1, r_s2, r_s3, w_echo, w_rise, w_fall;
  logic r_first, r_to_p, r_ov_p;
  logic [PW-1:0] r_per;
  logic [CW-1:0] r_cyc;
  logic [TW-1:0] r_tick;
  logic [DW-1:0] r_acc, w_inc;
  logic w_all9, w_carry, w_wrap, w_per_hit, w_enter_trig;
`ifdef US_ECHO_FILTER_EN
  localparam int FW = $clog2(ECHO_FILT_LEN);
  logic r_filt;
  logic [FW-1:0] r_fcnt;
  // filtered echo flips only after ECHO_FILT_LEN consecutive differing samples
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (r_s2 == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FW'(ECHO_FILT_LEN - 1)) begin
      r_filt <= r_s2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end
  assign w_echo = r_filt;
`else
  assign w_echo = r_s2;
`endif
  assign w_rise = w_echo & ~r_s3;
  assign w_fall = ~w_echo & r_s3;
  assign w_per_hit = r_first | (r_per == PW'(PERIOD_CYC - 1));
  assign w_wrap = r_tick == TW'(TICK_DIV - 1);
  assign w_enter_trig = (r_state == S_IDLE) && (w_next == S_TRIG);
  always_comb begin
    w_inc = r_acc;
    w_all9 = 1'b1;
    w_carry = 1'b1;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      w_all9 = w_all9 & (r_acc[4*d +: 4] == 4'd9);
      if (w_carry) begin
        w_inc[4*d +: 4] = (r_acc[4*d +: 4] == 4'd9) ? 4'd0 : r_acc[4*d +: 4] + 4'd1;
        w_carry = r_acc[4*d +: 4] == 4'd9;
      end
    end
  end
  always_ff @(posedge CLK_50M) begin
    if (RST) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = ((mode && w_per_hit) || (!mode && start)) ? S_TRIG : S_IDLE;
      S_TRIG: w_next = (r_cyc == CW'(TRIG_HIGH_CYC - 1)) ? S_WAIT : S_TRIG;
      S_WAIT: w_next = w_rise ? S_MEAS : (r_cyc == CW'(RISE_TIMEOUT_CYC - 1)) ? S_DONE : S_WAIT;
      S_MEAS: w_next = w_fall ? S_DONE : S_MEAS;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    Trig = r_state == S_TRIG;
    busy = r_state != S_IDLE;
  end
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      {r_s1, r_s2, r_s3} <= '0;
      r_first <= 1'b1;
      r_to_p <= 1'b0;
      r_ov_p <= 1'b0;
      r_per <= '0;
      r_cyc <= '0;
      r_tick <= '0;
      r_acc <= '0;
      data <= '0;
      data_valid <= 1'b0;
      timeout <= 1'b0;
      overrange <= 1'b0;
    end else begin
      r_s1 <= Echo;
      r_s2 <= r_s1;
      r_s3 <= w_echo;
      r_cyc <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cyc + 1'b1;
      r_per <= w_enter_trig ? '0 : (r_per == PW'(PERIOD_CYC - 1)) ? r_per : r_per + 1'b1;
      if (w_enter_trig) begin
        r_first <= 1'b0;
        r_to_p <= 1'b0;
        r_ov_p <= 1'b0;
      end
      if (r_state == S_WAIT && w_next == S_DONE) r_to_p <= 1'b1;
      if (r_state == S_WAIT && w_next == S_MEAS) begin
        r_tick <= '0;
        r_acc <= '0;
      end
      if (r_state == S_MEAS) begin
        r_tick <= w_wrap ? '0 : r_tick + 1'b1;
        if (w_wrap && w_all9) r_ov_p <= 1'b1;
        if (w_wrap && !w_all9) r_acc <= w_inc;
      end
      data_valid <= r_state == S_DONE;
      if (r_state == S_DONE) begin
        data <= r_to_p ? '0 : r_acc;
        timeout <= r_to_p;
        overrange <= r_ov_p;
      end
    end
  end
endmodule
